// File: rtl/g_alu32_pkg.sv
// Shared definitions for the ALU32 datapath blocks.
//   WIDTH  : operand/result width
//   SLICE  : bits handled per clock by the sequential subtractor
//   NSLICE : number of slices per operand
//   KW     : width of the slice index counter
//   SW     : log2(SLICE), used to turn a slice index into a bit offset
//   state_t: control states of the sequential subtractor
package g_alu32_pkg;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = $clog2(NSLICE);
    localparam int SW     = $clog2(SLICE);

    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/g_slice_add4.sv
// Combinational SLICE-bit ripple-carry adder used as the per-cycle
// arithmetic element of the sequential subtractor.
//   A, B : addends
//   CI   : carry in
//   S    : sum
//   CO   : carry out (top bit of the SLICE+1-bit internal sum)
module g_slice_add4
    import g_alu32_pkg::*;
(
    input  logic [SLICE-1:0] A,
    input  logic [SLICE-1:0] B,
    input  logic             CI,
    output logic [SLICE-1:0] S,
    output logic             CO
);

    logic [SLICE:0] carry;

    assign carry[0] = CI;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            assign S[gi]         = A[gi] ^ B[gi] ^ carry[gi];
            assign carry[gi + 1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign CO = carry[SLICE];

endmodule

// File: rtl/g_subtractor32_seq.sv
// Multi-cycle subtractor: Out = In1 - In2 - BI, computed SLICE bits per
// clock (least-significant slice first) as In1 + ~In2 + ~BI through a
// single reused slice adder.
//   CLK, Reset      : clock, synchronous active-high reset
//   Start, Enable   : request (accepted in IDLE only when Enable=1),
//                     advance qualifier (0 stalls RUN)
//   In1, In2, BI    : minuend, subtrahend, borrow in
//   Busy, Done      : operation in progress, one-cycle completion pulse
//   Out, BO         : registered difference, borrow out
//   Zero, Overflow  : Out == 0, signed overflow of the subtraction
module g_subtractor32_seq
    import g_alu32_pkg::*;
(
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Enable,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             BI,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Out,
    output logic             BO,
    output logic             Zero,
    output logic             Overflow
);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg;        // latched minuend
    logic [WIDTH-1:0]   b_reg;        // latched, already inverted subtrahend
    logic [WIDTH-1:0]   res_reg;      // result shift register, fills from the top
    logic               carry_reg;    // only path for carry between cycles
    logic [KW-1:0]      k_reg;
    logic [WIDTH-1:0]   out_reg;
    logic               bo_reg;
    logic               zero_reg;
    logic               overflow_reg;

    logic [KW+SW-1:0]   slice_base;
    logic [SLICE-1:0]   slice_a;
    logic [SLICE-1:0]   slice_b;
    logic [SLICE-1:0]   slice_s;
    logic               slice_co;
    logic [WIDTH-1:0]   res_next;
    logic               accept;
    logic               last_slice;

    assign slice_base = {k_reg, {SW{1'b0}}};
    assign slice_a    = a_reg[slice_base +: SLICE];
    assign slice_b    = b_reg[slice_base +: SLICE];

    g_slice_add4 u_slice (
        .A  (slice_a),
        .B  (slice_b),
        .CI (carry_reg),
        .S  (slice_s),
        .CO (slice_co)
    );

    // New slice enters at the top; after NSLICE shifts slice 0 sits at bit 0.
    assign res_next   = {slice_s, res_reg[WIDTH-1:SLICE]};
    assign accept     = (state_reg == IDLE) && Start && Enable;
    assign last_slice = (state_reg == RUN) && Enable && (k_reg == K_LAST);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start && Enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (Enable && (k_reg == K_LAST)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Busy       = 1'b1;
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The result registers are loaded on the clock edge that enters DONE,
    // so Out/BO/Zero/Overflow are already valid during the Done pulse and
    // then hold until the next completing operation.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            a_reg        <= '0;
            b_reg        <= '0;
            res_reg      <= '0;
            carry_reg    <= 1'b0;
            k_reg        <= '0;
            out_reg      <= '0;
            bo_reg       <= 1'b0;
            zero_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (accept) begin
                a_reg     <= In1;
                b_reg     <= ~In2;
                carry_reg <= ~BI;
                k_reg     <= '0;
            end
            if ((state_reg == RUN) && Enable) begin
                res_reg   <= res_next;
                carry_reg <= slice_co;
                k_reg     <= k_reg + KW'(1);
            end
            if (last_slice) begin
                out_reg      <= res_next;
                bo_reg       <= ~slice_co;
                zero_reg     <= (res_next == '0);
                // b_reg holds ~In2, so In2's sign is ~b_reg[WIDTH-1].
                overflow_reg <= (a_reg[WIDTH-1] != ~b_reg[WIDTH-1]) &&
                                (res_next[WIDTH-1] != a_reg[WIDTH-1]);
            end
        end
    end

    assign Out      = out_reg;
    assign BO       = bo_reg;
    assign Zero     = zero_reg;
    assign Overflow = overflow_reg;

endmodule
